// File: rtl/mips_pkg.sv
// Shared MIPS front-end constants: datapath width, PC step and reset vector.
package mips_pkg;
   localparam int          ADDR_W   = 32;
   localparam int          INSTR_W  = 32;
   localparam int          PC_STEP  = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/i_fetch_if.sv
// Fetch-unit bus: instruction ROM port, redirect input and decode-side handshake.
interface i_fetch_if #(parameter int ADDR_W = mips_pkg::ADDR_W);
   logic [ADDR_W-1:0] imem_addr;
   logic [ADDR_W-1:0] imem_data;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] out_instr;
   logic [ADDR_W-1:0] out_pc;

   modport master (
      output imem_addr, out_valid, out_instr, out_pc,
      input  imem_data, redirect_valid, redirect_pc, out_ready
   );

   modport slave (
      input  imem_addr, out_valid, out_instr, out_pc,
      output imem_data, redirect_valid, redirect_pc, out_ready
   );
endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: power-of-two depth, flush has priority, storage cleared on reset.
module fetch_fifo #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 64,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [CNT_W-1:0] count
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
         if (push && !pop)      count_d = count_q + 1'b1;
         else if (pop && !push) count_d = count_q - 1'b1;
      end
   end

   // NOTE: state flops use non-blocking assignments; the combinational block above uses blocking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: storage is reset so the head outputs are never X, even while empty.
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;
endmodule

// File: rtl/i_fetch.sv
// Instruction fetch with prefetch FIFO and redirect flush.
// Optional I_FETCH_PERF_EN adds saturating perf_fetched / perf_stall counters.
module i_fetch
   import mips_pkg::*;
#(
   parameter int                ADDR_W   = mips_pkg::ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(mips_pkg::RESET_PC),
   parameter int                DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst_n,
`ifdef I_FETCH_PERF_EN
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stall,
`endif
   i_fetch_if.master   bus
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
   logic [CNT_W-1:0]    count;
   logic [2*ADDR_W-1:0] fifo_dout;
   logic                out_valid;
   logic                push;
   logic                pop;

   assign out_valid = (count != '0);
   assign pop       = out_valid && bus.out_ready;
   // A full buffer still accepts a fetch when the head leaves in the same cycle.
   assign push      = !bus.redirect_valid && ((count < CNT_W'(DEPTH)) || pop);

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      if (bus.redirect_valid) fetch_pc_d = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
      else if (push)          fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fetch_pc_q <= RESET_PC;
      else        fetch_pc_q <= fetch_pc_d;
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (2*ADDR_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (bus.redirect_valid),
      .din   ({fetch_pc_q, bus.imem_data}),
      .dout  (fifo_dout),
      .count (count)
   );

   assign bus.imem_addr = fetch_pc_q;
   assign bus.out_valid = out_valid;
   assign bus.out_pc    = fifo_dout[2*ADDR_W-1:ADDR_W];
   assign bus.out_instr = fifo_dout[ADDR_W-1:0];

`ifdef I_FETCH_PERF_EN
   logic [31:0] perf_fetched_q, perf_fetched_d;
   logic [31:0] perf_stall_q, perf_stall_d;
   logic        stall;

   assign stall = (count == CNT_W'(DEPTH)) && !pop && !bus.redirect_valid;

   always_comb begin
      perf_fetched_d = perf_fetched_q;
      perf_stall_d   = perf_stall_q;
      if (push  && (perf_fetched_q != 32'hFFFF_FFFF)) perf_fetched_d = perf_fetched_q + 32'd1;
      if (stall && (perf_stall_q   != 32'hFFFF_FFFF)) perf_stall_d   = perf_stall_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched_q <= '0;
         perf_stall_q   <= '0;
      end else begin
         perf_fetched_q <= perf_fetched_d;
         perf_stall_q   <= perf_stall_d;
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_stall   = perf_stall_q;
`endif
endmodule

// File: doc/i_fetch.md
I_FETCH -- requirements
Module: i_fetch

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, the address/PC and instruction width in bits.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-003 The block SHALL have parameter DEPTH, default 4, the prefetch buffer entries (power of two, >=2).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 imem_addr  output  ADDR_W  byte address driven to the instruction ROM.
REQ-007 imem_data  input  ADDR_W  instruction word returned combinationally by the ROM, same cycle.
REQ-008 redirect_valid  input  1  branch/jump taken; flush and restart fetch.
REQ-009 redirect_pc  input  ADDR_W  new fetch address when redirect_valid=1.
REQ-010 out_valid  output  1  buffer head holds a valid instruction.
REQ-011 out_ready  input  1  decode stage accepts head this cycle.
REQ-012 out_instr  output  ADDR_W  instruction at buffer head.
REQ-013 out_pc  output  ADDR_W  byte address of out_instr.

Function
REQ-014 The block SHALL hold a fetch_pc register and drive imem_addr = fetch_pc continuously.
REQ-015 push = !redirect_valid && (count < DEPTH || pop); pop = out_valid && out_ready.
REQ-016 On push the block SHALL write {fetch_pc, imem_data} to the buffer tail and set fetch_pc <= fetch_pc + 4 (modulo 2^ADDR_W, wrap to 0 without error).
REQ-017 Buffer SHALL be FIFO ordered; out_instr/out_pc SHALL reflect the head entry; out_valid = (count != 0).
REQ-018 Simultaneous push and pop SHALL leave count unchanged, including when full (pass-through of one slot); read and write pointers wrap modulo DEPTH.
REQ-019 When empty, a push SHALL make out_valid=1 on the next cycle (1-cycle fetch-to-output latency); no same-cycle bypass.
REQ-020 redirect_valid=1 SHALL take priority over push and pop: count <= 0, pointers <= 0, fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00}; out_valid=0 the next cycle; first redirected instruction visible 2 cycles after redirect.
REQ-021 A pop in the same cycle as redirect SHALL still be considered consumed by decode; the entry is discarded by the flush regardless.
REQ-022 out_instr/out_pc SHALL be don't-care when out_valid=0 but SHALL NOT be X after reset (buffer storage reset to 0).

Reset
REQ-023 While rst_n=0: fetch_pc=RESET_PC, count=0, pointers=0, out_valid=0, imem_addr=RESET_PC, out_instr=0, out_pc=0.
REQ-024 Reset asserted mid-operation SHALL discard all buffered entries immediately (asynchronous); fetch restarts at RESET_PC on the first clock edge after rst_n rises.

Configuration
REQ-025 Macro I_FETCH_PERF_EN, when defined, SHALL add outputs perf_fetched (32-bit, increments per push) and perf_stall (32-bit, increments each cycle count==DEPTH && !pop && !redirect_valid), both reset to 0, saturating at 32'hFFFF_FFFF.
REQ-026 Without I_FETCH_PERF_EN, those ports and counters SHALL NOT exist; all other behaviour identical.

Structure
REQ-027 Shared package mips_pkg SHALL hold ADDR_W, INSTR_W, PC_STEP (=4) and RESET_PC defaults; i_fetch SHALL import them.
REQ-028 The buffer SHALL be a sub-module fetch_fifo (parameters DEPTH, WIDTH=2*ADDR_W; ports push, pop, flush, din, dout, count), reset asynchronously with rst_n.

Verification
REQ-029 Reset release, out_ready=1, ROM word i = i: out_pc sequence 0,4,8,12 with out_instr 0,1,2,3, out_valid=1 from cycle 2 onward.
REQ-030 out_ready=0 for 10 cycles: count saturates at 4, imem_addr frozen at 16, no entry lost; release -> instructions at 0..12 then 16 in order.
REQ-031 Redirect to 32'h0000_0043 while 3 entries buffered: out_valid=0 next cycle, next out_pc=32'h0000_0040, stale entries never delivered.
REQ-032 redirect_pc=32'hFFFF_FFFC then free-run: out_pc 32'hFFFF_FFFC followed by 32'h0000_0000.
REQ-033 rst_n pulsed low mid-stream with buffer full: out_valid=0 immediately (asynchronously), next delivered out_pc=RESET_PC.
REQ-034 With I_FETCH_PERF_EN: 4 pushes then 6 stalled cycles -> perf_fetched=4, perf_stall=6; build without macro compiles with no perf ports.
